pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle/multi-cycle CPU datapath. It holds the fetch address and selects the next PC internally: sequential, branch, jump, jump-register or exception vector. It also provides stall, halt/resume and a boot cycle after reset. It replaces the plain PC register and the external next-PC mux. It feeds instruction memory and the link-register path.

Parameters:
WIDTH, 32, address width in bits; must be >= 28
RESET_VECTOR, 32'h0000_0000, Address value while in reset and during the boot cycle
EXC_VECTOR, 32'h0000_0080, target address on exception
INC, 4, sequential increment in bytes

Ports:
Clk  input  1  clock; all state changes on rising edge
Clrn  input  1  asynchronous active-low reset; 0 forces reset state immediately
Stall  input  1  hold PC (pipeline/memory wait)
Halt  input  1  enter halted state
Resume  input  1  leave halted state
Branch_Taken  input  1  conditional branch resolved taken
Branch_Offset  input  WIDTH  sign-extended word offset
Jump  input  1  absolute jump (J/JAL)
Jump_Index  input  26  instruction index field
Jr  input  1  jump to register
Jr_Addr  input  WIDTH  register target
Exc  input  1  exception request
Address  output  WIDTH  current fetch address (registered)
Address_Plus4  output  WIDTH  Address+INC (combinational, for link)
Valid  output  1  Address is a real fetch (registered)
Fault  output  1  one-cycle pulse: misaligned Jr target (registered)

Behaviour:
- Reset (Clrn=0, async): Address=RESET_VECTOR, Valid=0, Fault=0, state=BOOT.
- States: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after Clrn deasserts. Address stays RESET_VECTOR and Valid=0. Next state is RUN with Valid=1. Address is unchanged, so the first fetch is RESET_VECTOR.
- RUN: next Address by priority Exc > Stall > Jr > Jump > Branch_Taken > sequential.
  - Exc: EXC_VECTOR. Exc overrides Stall and Halt.
  - Stall: hold Address.
  - Jr: {Jr_Addr[WIDTH-1:2],2'b00}. If Jr_Addr[1:0]!=0, Fault=1 for one cycle.
  - Jump: {Address_Plus4[WIDTH-1:28], Jump_Index, 2'b00}.
  - Branch: Address_Plus4 + (Branch_Offset<<2).
  - Sequential: Address_Plus4.
- Arithmetic is modulo 2^WIDTH; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Halt in RUN (no Exc): Address holds and state goes to HALT. Valid=0 from the next cycle.
- HALT:
  - Address holds and Valid=0.
  - Resume=1 goes to RUN: Valid=1 next cycle, Address unchanged.
  - Exc in HALT: Address=EXC_VECTOR, state=RUN, Valid=1.
  - Halt and Resume together in HALT: Resume wins. In RUN, Halt wins.
- Fault clears the next cycle unless re-triggered. Fault is never set by Stall/Exc cycles.
- Clrn asserted mid-operation in any state: immediate return to reset values.

Optional Feature:
Macro PC_EPC_EN.
- Defined:
  - Adds input Eret (1) and output Epc (WIDTH), reset 0.
  - On an accepted Exc, Epc <= Address, the faulting PC.
  - Eret in RUN, below Exc and above Stall: Address <= Epc.
- Undefined: no Eret/Epc ports and no EPC register.

Test Plan:
- Clrn=0 then release: Address=0, Valid=0 for 1 cycle -> Valid=1, then Address 0,4,8 on successive edges.
- Address=0x100, Branch_Taken=1, Branch_Offset=-2 -> next Address=0xFC.
- Address=0x1000_0000, Jump=1, Jump_Index=0x0000040 -> 0x1000_0100. Jr=1 with Jr_Addr=0x203 and Jump=1 together -> Address=0x200, Fault=1 for one cycle.
- Stall=1 for 3 cycles with Jump asserted -> Address held; Exc=1 during Stall -> Address=0x80 next edge.
- Halt=1 at Address=0x40 -> Valid=0 and Address stays 0x40; Resume=1 -> Valid=1 and fetch resumes 0x40,0x44.
- PC_EPC_EN: Exc at Address=0x300 -> Address=0x80, Epc=0x300; Eret=1 -> Address=0x300. Clrn pulse mid-run -> Address=0, Epc=0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit with an internal next-PC select.
//
// Holds the fetch address and picks the next one from exception vector, hold,
// jump-register, absolute jump, taken branch or sequential increment. A one-cycle
// BOOT state follows reset, and a HALT state parks the PC until Resume or Exc.
//
// Optional feature (macro PC_EPC_EN): adds an exception PC register. Epc captures
// the address at an accepted Exc, and Eret returns the fetch address to Epc.
//
// Ports:
//   Clk            clock, rising edge
//   Clrn           asynchronous active-low reset
//   Stall          hold the PC
//   Halt / Resume  enter / leave the halted state
//   Branch_Taken   take Address_Plus4 + (Branch_Offset << 2)
//   Branch_Offset  sign-extended word offset
//   Jump           absolute jump to {Address_Plus4[top:28], Jump_Index, 2'b00}
//   Jump_Index     26-bit instruction index
//   Jr / Jr_Addr   jump to register (low two bits forced to zero)
//   Exc            exception request, jumps to EXC_VECTOR
//   Eret / Epc     (PC_EPC_EN only) return from exception / saved exception PC
//   Address        registered fetch address
//   Address_Plus4  Address + INC, combinational, for the link path
//   Valid          Address is a real fetch
//   Fault          one-cycle pulse on a misaligned Jr target
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int unsigned      INC          = 4
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             Resume,
  input  logic             Branch_Taken,
  input  logic [WIDTH-1:0] Branch_Offset,
  input  logic             Jump,
  input  logic [25:0]      Jump_Index,
  input  logic             Jr,
  input  logic [WIDTH-1:0] Jr_Addr,
  input  logic             Exc,
`ifdef PC_EPC_EN
  input  logic             Eret,
  output logic [WIDTH-1:0] Epc,
`endif
  output logic [WIDTH-1:0] Address,
  output logic [WIDTH-1:0] Address_Plus4,
  output logic             Valid,
  output logic             Fault
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] plus_inc;
  logic [WIDTH-1:0] jr_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] branch_tgt;

  logic             eret_req;
  logic [WIDTH-1:0] epc_val;

  // Candidate targets; all arithmetic wraps modulo 2^WIDTH.
  assign plus_inc   = addr_q + WIDTH'(INC);
  assign jr_tgt     = {Jr_Addr[WIDTH-1:2], 2'b00};
  // Keep the region bits above bit 27 of the incremented PC, splice in the index.
  assign jump_tgt   = ((plus_inc >> 28) << 28) | WIDTH'({Jump_Index, 2'b00});
  assign branch_tgt = plus_inc + (Branch_Offset << 2);

`ifdef PC_EPC_EN
  logic [WIDTH-1:0] epc_q, epc_d;

  // Any accepted exception (RUN or HALT) saves the PC it interrupted.
  always_comb begin
    epc_d = epc_q;
    if (Exc && (state_q != StBoot)) begin
      epc_d = addr_q;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      epc_q <= '0;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign eret_req = Eret;
  assign epc_val  = epc_q;
  assign Epc      = epc_q;
`else
  assign eret_req = 1'b0;
  assign epc_val  = '0;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Halt wins over Resume in RUN; Resume wins in HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!Exc && Halt) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (Exc || Resume) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Next address, valid and fault.
  always_comb begin
    addr_d  = addr_q;
    fault_d = 1'b0;
    case (state_q)
      StRun: begin
        if (Exc) begin
          addr_d = EXC_VECTOR;
        end else if (Halt) begin
          addr_d = addr_q;
        end else if (eret_req) begin
          addr_d = epc_val;
        end else if (Stall) begin
          addr_d = addr_q;
        end else if (Jr) begin
          addr_d  = jr_tgt;
          fault_d = |Jr_Addr[1:0];
        end else if (Jump) begin
          addr_d = jump_tgt;
        end else if (Branch_Taken) begin
          addr_d = branch_tgt;
        end else begin
          addr_d = plus_inc;
        end
      end
      StHalt: begin
        if (Exc) begin
          addr_d = EXC_VECTOR;
        end
      end
      default: addr_d = addr_q;
    endcase
    valid_d = (state_d == StRun);
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      addr_q  <= RESET_VECTOR;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign Address       = addr_q;
  assign Address_Plus4 = plus_inc;
  assign Valid         = valid_q;
  assign Fault         = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (default build, PC_EPC_EN undefined).
// Directed steps from the test plan, then randomized cycles against a
// behavioural model of the PC rules.
module tb_pc_unit;

  localparam logic [31:0] ExcVec = 32'h0000_0080;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic        Stall, Halt, Resume, Branch_Taken, Jump, Jr, Exc;
  logic [31:0] Branch_Offset, Jr_Addr;
  logic [25:0] Jump_Index;
  logic [31:0] Address, Address_Plus4;
  logic        Valid, Fault;

  int vectors = 0;
  int miscompares = 0;

  // Model state: 0 = boot, 1 = running, 2 = halted.
  int          m_mode;
  logic [31:0] m_addr;
  logic        m_fault;

  pc_unit dut (
    .Clk          (Clk),
    .Clrn         (Clrn),
    .Stall        (Stall),
    .Halt         (Halt),
    .Resume       (Resume),
    .Branch_Taken (Branch_Taken),
    .Branch_Offset(Branch_Offset),
    .Jump         (Jump),
    .Jump_Index   (Jump_Index),
    .Jr           (Jr),
    .Jr_Addr      (Jr_Addr),
    .Exc          (Exc),
    .Address      (Address),
    .Address_Plus4(Address_Plus4),
    .Valid        (Valid),
    .Fault        (Fault)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Stall = 0; Halt = 0; Resume = 0; Branch_Taken = 0; Jump = 0; Jr = 0; Exc = 0;
    Branch_Offset = '0; Jr_Addr = '0; Jump_Index = '0;
  endtask

  // Next state from the written rules, using the inputs present at the edge.
  task automatic model_edge();
    logic [31:0] nxt;
    nxt     = m_addr + 32'd4;
    m_fault = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (Exc) m_addr = ExcVec;
      else if (Halt) m_mode = 2;
      else if (Stall) m_addr = m_addr;
      else if (Jr) begin
        m_addr  = Jr_Addr - (Jr_Addr % 4);
        m_fault = (Jr_Addr % 4) != 0;
      end else if (Jump) m_addr = (nxt & 32'hF000_0000) + 32'(Jump_Index) * 4;
      else if (Branch_Taken) m_addr = nxt + Branch_Offset * 4;
      else m_addr = nxt;
    end else begin
      if (Exc) begin
        m_addr = ExcVec;
        m_mode = 1;
      end else if (Resume) m_mode = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"}, Address, m_addr);
    check({tag, ".plus4"}, Address_Plus4, m_addr + 32'd4);
    check({tag, ".valid"}, {31'd0, Valid}, {31'd0, m_mode == 1});
    check({tag, ".fault"}, {31'd0, Fault}, {31'd0, m_fault});
  endtask

  // One clock: model and DUT advance together, compare 1 time unit later.
  task automatic step(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    Clrn = 1'b0;
    #1;
    m_mode = 0; m_addr = 32'h0; m_fault = 1'b0;
    check_all(tag);
    @(negedge Clk);
    Clrn = 1'b1;
  endtask

  task automatic goto_addr(input logic [31:0] a);
    Jr = 1; Jr_Addr = a;
    step("goto");
    idle();
  endtask

  initial begin
    idle();
    Clrn = 1'b1;
    #2;
    do_reset("reset");
    check("reset_addr_const", Address, 32'h0);

    // Boot cycle then sequential 0, 4, 8.
    step("boot");
    check("boot_first_fetch", Address, 32'h0);
    check("boot_valid", {31'd0, Valid}, 32'd1);
    step("seq4");
    check("seq4_const", Address, 32'h4);
    step("seq8");
    check("seq8_const", Address, 32'h8);

    // Branch backwards.
    goto_addr(32'h100);
    Branch_Taken = 1; Branch_Offset = -32'sd2;
    step("branch");
    check("branch_const", Address, 32'hFC);
    idle();

    // Absolute jump keeps region bits.
    goto_addr(32'h1000_0000);
    Jump = 1; Jump_Index = 26'h40;
    step("jump");
    check("jump_const", Address, 32'h1000_0100);

    // Jr beats Jump and flags misalignment for one cycle.
    Jr = 1; Jr_Addr = 32'h203;
    step("jr_mis");
    check("jr_mis_const", Address, 32'h200);
    check("jr_fault_const", {31'd0, Fault}, 32'd1);
    idle();
    step("fault_clear");

    // Stall with Jump held, then Exc overrides the stall.
    Stall = 1; Jump = 1; Jump_Index = 26'h3FF_FFFF;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall_const", Address, 32'h204);
    Exc = 1;
    step("exc_stall");
    check("exc_const", Address, ExcVec);
    idle();

    // Halt, idle in halt, resume.
    goto_addr(32'h40);
    Halt = 1;
    step("halt");
    check("halt_valid", {31'd0, Valid}, 32'd0);
    Halt = 0;
    step("halted");
    Resume = 1;
    step("resume");
    check("resume_const", Address, 32'h40);
    Resume = 0;
    step("resume_seq");
    check("resume_seq_const", Address, 32'h44);

    // Halt+Resume in HALT: Resume wins. Exc in HALT goes to the vector.
    Halt = 1;
    step("halt2");
    Resume = 1;
    step("halt_resume");
    check("halt_resume_valid", {31'd0, Valid}, 32'd1);
    Resume = 0;
    step("halt3");
    Halt = 0; Exc = 1;
    step("exc_halt");
    check("exc_halt_valid", {31'd0, Valid}, 32'd1);
    idle();

    // Wrap at top of address space.
    goto_addr(32'hFFFF_FFFC);
    step("wrap");
    check("wrap_const", Address, 32'h0);

    // Reset mid-run.
    do_reset("midreset");
    step("boot2");

    // Randomized cycles.
    for (int n = 0; n < 400; n++) begin
      Stall         = ($urandom_range(0, 7) == 0);
      Halt          = ($urandom_range(0, 11) == 0);
      Resume        = ($urandom_range(0, 2) == 0);
      Exc           = ($urandom_range(0, 15) == 0);
      Jr            = ($urandom_range(0, 5) == 0);
      Jump          = ($urandom_range(0, 5) == 0);
      Branch_Taken  = ($urandom_range(0, 3) == 0);
      Branch_Offset = 32'($signed(16'($urandom)));
      Jr_Addr       = $urandom;
      Jump_Index    = 26'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        idle();
        do_reset("rnd_reset");
      end else begin
        step("rnd");
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
